// File: rtl/spi_frame_receiver.sv
// SPI slave receiver that assembles multi-channel audio frames from a serial bit stream.
// Completed words and whole frames are published with single-cycle strobes; truncated frames are flagged.
module spi_frame_receiver #(
  parameter int  WORD_WIDTH   = 16,
  parameter int  NUM_CHANNELS = 2,
  parameter bit  LSB_FIRST    = 1'b0,
  parameter bit  CONTINUOUS   = 1'b0,
  localparam int CHAN_BITS    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int FRAME_BITS   = NUM_CHANNELS * WORD_WIDTH
) (
  input  logic                  serial_clk,
  input  logic                  reset,
  input  logic                  chip_select,
  input  logic                  mosi,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic [CHAN_BITS-1:0]  word_chan,
  output logic                  word_valid,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [WORD_WIDTH-1:0] shift_reg_out
);

  localparam int BIT_BITS = $clog2(WORD_WIDTH);
  localparam logic [BIT_BITS-1:0]  LAST_BIT  = BIT_BITS'(WORD_WIDTH - 1);
  localparam logic [BIT_BITS-1:0]  BIT_ONE   = BIT_BITS'(1);
  localparam logic [CHAN_BITS-1:0] LAST_CHAN = CHAN_BITS'(NUM_CHANNELS - 1);
  localparam logic [CHAN_BITS-1:0] CHAN_ONE  = CHAN_BITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] sr, sr_n, sr_shift;
  logic [BIT_BITS-1:0]   bit_cnt, bit_n;
  logic [CHAN_BITS-1:0]  chan_cnt, chan_n;
  logic [FRAME_BITS-1:0] staging, staging_n;
  logic [WORD_WIDTH-1:0] word_out_n;
  logic [CHAN_BITS-1:0]  word_chan_n;
  logic                  word_valid_n;
  logic [FRAME_BITS-1:0] data_out_n;
  logic                  frame_valid_n;
  logic                  frame_error_n;

  assign sr_shift = LSB_FIRST ? {mosi, sr[WORD_WIDTH-1:1]} : {sr[WORD_WIDTH-2:0], mosi};
  assign shift_reg_out = sr;

  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      chan_cnt    <= '0;
      staging     <= '0;
      word_out    <= '0;
      word_chan   <= '0;
      word_valid  <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_n;
      chan_cnt    <= chan_n;
      staging     <= staging_n;
      word_out    <= word_out_n;
      word_chan   <= word_chan_n;
      word_valid  <= word_valid_n;
      data_out    <= data_out_n;
      frame_valid <= frame_valid_n;
      frame_error <= frame_error_n;
    end
  end

  always_comb begin
    state_n       = state;
    sr_n          = sr;
    bit_n         = bit_cnt;
    chan_n        = chan_cnt;
    staging_n     = staging;
    word_out_n    = word_out;
    word_chan_n   = word_chan;
    word_valid_n  = 1'b0;
    data_out_n    = data_out;
    frame_valid_n = 1'b0;
    frame_error_n = 1'b0;

    if (chip_select) begin
      // Entering SHIFT always samples a bit, so nonzero counters mean a partial frame.
      state_n = IDLE;
      sr_n    = '0;
      bit_n   = '0;
      chan_n  = '0;
      if (state == SHIFT && (bit_cnt != '0 || chan_cnt != '0))
        frame_error_n = 1'b1;
    end else if (state == IDLE || state == SHIFT) begin
      state_n = SHIFT;
      if (bit_cnt == LAST_BIT) begin
        word_out_n   = sr_shift;
        word_chan_n  = chan_cnt;
        word_valid_n = 1'b1;
        staging_n[int'(chan_cnt)*WORD_WIDTH +: WORD_WIDTH] = sr_shift;
        sr_n  = '0;
        bit_n = '0;
        if (chan_cnt == LAST_CHAN) begin
          data_out_n    = staging_n;
          frame_valid_n = 1'b1;
          chan_n        = '0;
          state_n       = CONTINUOUS ? SHIFT : HOLD;
        end else begin
          chan_n = chan_cnt + CHAN_ONE;
        end
      end else begin
        sr_n  = sr_shift;
        bit_n = bit_cnt + BIT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: three parameter variants share one serial stream; a frame-level
// model queues expected words/frames/errors and a negedge monitor pops and compares them.
module tb_spi_frame_receiver;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int NW = W * N;
  localparam int NI = 3;

  logic serial_clk = 1'b0;
  logic reset;
  logic chip_select;
  logic mosi;

  logic [W-1:0]  word_out      [NI];
  logic [0:0]    word_chan     [NI];
  logic          word_valid    [NI];
  logic [NW-1:0] data_out      [NI];
  logic          frame_valid   [NI];
  logic          frame_error   [NI];
  logic [W-1:0]  shift_reg_out [NI];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_frame_cycle [NI];
  int prev_frame_cycle [NI];

  bit            burst [$];
  logic [16:0]   exp_word_q  [NI][$];
  logic [NW-1:0] exp_frame_q [NI][$];
  logic [NW-1:0] exp_err_q   [NI][$];
  logic [NW-1:0] model_data  [NI];

  always #5 serial_clk = ~serial_clk;
  always @(posedge serial_clk) cycle <= cycle + 1;

  spi_frame_receiver #(.WORD_WIDTH(W), .NUM_CHANNELS(N), .LSB_FIRST(1'b0), .CONTINUOUS(1'b0)) dut_msb (
    .serial_clk(serial_clk), .reset(reset), .chip_select(chip_select), .mosi(mosi),
    .word_out(word_out[0]), .word_chan(word_chan[0]), .word_valid(word_valid[0]),
    .data_out(data_out[0]), .frame_valid(frame_valid[0]), .frame_error(frame_error[0]),
    .shift_reg_out(shift_reg_out[0]));

  spi_frame_receiver #(.WORD_WIDTH(W), .NUM_CHANNELS(N), .LSB_FIRST(1'b1), .CONTINUOUS(1'b0)) dut_lsb (
    .serial_clk(serial_clk), .reset(reset), .chip_select(chip_select), .mosi(mosi),
    .word_out(word_out[1]), .word_chan(word_chan[1]), .word_valid(word_valid[1]),
    .data_out(data_out[1]), .frame_valid(frame_valid[1]), .frame_error(frame_error[1]),
    .shift_reg_out(shift_reg_out[1]));

  spi_frame_receiver #(.WORD_WIDTH(W), .NUM_CHANNELS(N), .LSB_FIRST(1'b0), .CONTINUOUS(1'b1)) dut_cont (
    .serial_clk(serial_clk), .reset(reset), .chip_select(chip_select), .mosi(mosi),
    .word_out(word_out[2]), .word_chan(word_chan[2]), .word_valid(word_valid[2]),
    .data_out(data_out[2]), .frame_valid(frame_valid[2]), .frame_error(frame_error[2]),
    .shift_reg_out(shift_reg_out[2]));

  function automatic bit cfg_lsb(input int i);
    return (i == 1);
  endfunction

  function automatic bit cfg_cont(input int i);
    return (i == 2);
  endfunction

  task automatic check_output(input string name, input int inst, input logic [127:0] actual,
                              input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at cycle %0d", name, inst, actual, expected, cycle);
    end
  endtask

  task automatic report_unexpected(input string name, input int inst);
    checks++;
    errors++;
    $display("[TB] FAIL %s inst%0d: strobe seen, none expected at cycle %0d", name, inst, cycle);
  endtask

  // Frame-level reference: chop the burst into words, group words into frames.
  task automatic model_burst(input bit by_reset);
    for (int i = 0; i < NI; i++) begin
      int n = burst.size();
      int cap = cfg_cont(i) ? n : ((n < NW) ? n : NW);
      int nwords = cap / W;
      logic [NW-1:0] frame = '0;
      for (int k = 0; k < nwords; k++) begin
        logic [W-1:0] val = '0;
        int ch = k % N;
        for (int b = 0; b < W; b++) begin
          if (cfg_lsb(i)) val[b] = burst[k*W + b];
          else            val[W-1-b] = burst[k*W + b];
        end
        exp_word_q[i].push_back({ch[0], val});
        frame[ch*W +: W] = val;
        if (ch == N - 1) begin
          exp_frame_q[i].push_back(frame);
          model_data[i] = frame;
        end
      end
      if (by_reset) model_data[i] = '0;
      else if (cfg_cont(i) ? (n % NW != 0) : (n < NW)) exp_err_q[i].push_back(model_data[i]);
    end
  endtask

  task automatic drive_bits();
    for (int k = 0; k < burst.size(); k++) begin
      @(negedge serial_clk);
      chip_select = 1'b0;
      mosi = burst[k];
    end
  endtask

  task automatic apply_stimulus(input int gap);
    model_burst(1'b0);
    drive_bits();
    @(negedge serial_clk);
    chip_select = 1'b1;
    mosi = 1'($urandom);
    repeat (gap) @(negedge serial_clk);
  endtask

  task automatic load_word(input logic [W-1:0] value, input bit lsb_first);
    for (int b = 0; b < W; b++) burst.push_back(lsb_first ? value[b] : value[W-1-b]);
  endtask

  task automatic load_random(input int n);
    for (int b = 0; b < n; b++) burst.push_back(1'($urandom));
  endtask

  always @(negedge serial_clk) begin
    for (int i = 0; i < NI; i++) begin
      if (word_valid[i] === 1'b1) begin
        if (exp_word_q[i].size() == 0) report_unexpected("word_valid", i);
        else check_output("word", i, {word_chan[i], word_out[i]}, exp_word_q[i].pop_front());
      end
      if (frame_valid[i] === 1'b1) begin
        prev_frame_cycle[i] = last_frame_cycle[i];
        last_frame_cycle[i] = cycle;
        check_output("frame_with_word", i, word_valid[i], 1'b1);
        if (exp_frame_q[i].size() == 0) report_unexpected("frame_valid", i);
        else check_output("frame", i, data_out[i], exp_frame_q[i].pop_front());
      end
      if (frame_error[i] === 1'b1) begin
        if (exp_err_q[i].size() == 0) report_unexpected("frame_error", i);
        else check_output("err_data_kept", i, data_out[i], exp_err_q[i].pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      model_data[i] = '0;
      last_frame_cycle[i] = 0;
      prev_frame_cycle[i] = 0;
    end
    reset = 1'b0;
    chip_select = 1'b0;
    mosi = 1'b0;

    $display("[TB] T1 reset held with activity on the link");
    for (int c = 0; c < 4; c++) begin
      @(negedge serial_clk);
      mosi = ~mosi;
      for (int i = 0; i < NI; i++)
        check_output("reset_outputs", i, {data_out[i], word_out[i], shift_reg_out[i], word_chan[i],
                     word_valid[i], frame_valid[i], frame_error[i]}, '0);
    end
    reset = 1'b1;
    chip_select = 1'b1;
    repeat (2) @(negedge serial_clk);

    $display("[TB] T2 stereo frame 0xA5C3 / 0x1234");
    burst.delete();
    load_word(16'hA5C3, 1'b0);
    load_word(16'h1234, 1'b0);
    apply_stimulus(3);
    check_output("t2_data_out", 0, data_out[0], 32'h1234_A5C3);

    $display("[TB] T3 single word 0x0001 sent LSB first");
    burst.delete();
    load_word(16'h0001, 1'b1);
    apply_stimulus(3);
    check_output("t3_lsb_word", 1, word_out[1], 16'h0001);
    check_output("t3_msb_word", 0, word_out[0], 16'h8000);

    $display("[TB] T4 truncated frame then full frame");
    burst.delete();
    load_random(20);
    apply_stimulus(3);
    check_output("t4_data_kept", 0, data_out[0], 32'h1234_A5C3);
    burst.delete();
    load_random(NW);
    apply_stimulus(3);

    $display("[TB] T5 back-to-back frames with chip select held low");
    burst.delete();
    load_random(2 * NW);
    apply_stimulus(3);
    check_output("t5_frame_spacing", 2, last_frame_cycle[2] - prev_frame_cycle[2], 32);
    check_output("t5_hold_data", 0, data_out[0], model_data[0]);
    check_output("t5_cont_data", 2, data_out[2], model_data[2]);

    $display("[TB] T6 reset in the middle of channel 1");
    burst.delete();
    load_random(W + 10);
    model_burst(1'b1);
    drive_bits();
    @(negedge serial_clk);
    reset = 1'b0;
    mosi = 1'($urandom);
    @(negedge serial_clk);
    for (int i = 0; i < NI; i++)
      check_output("t6_cleared", i, {data_out[i], word_out[i], shift_reg_out[i], word_chan[i]}, '0);
    reset = 1'b1;
    chip_select = 1'b1;
    repeat (2) @(negedge serial_clk);
    burst.delete();
    load_random(NW);
    apply_stimulus(3);

    $display("[TB] random bursts");
    for (int t = 0; t < 24; t++) begin
      int n;
      case ($urandom_range(0, 4))
        0: n = W;
        1: n = NW;
        2: n = 2 * NW;
        default: n = $urandom_range(1, 80);
      endcase
      burst.delete();
      load_random(n);
      apply_stimulus($urandom_range(1, 3));
    end

    repeat (4) @(negedge serial_clk);
    for (int i = 0; i < NI; i++) begin
      check_output("words_left", i, exp_word_q[i].size(), 0);
      check_output("frames_left", i, exp_frame_q[i].size(), 0);
      check_output("errors_left", i, exp_err_q[i].size(), 0);
      check_output("final_data", i, data_out[i], model_data[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
